mac_sample_source: RTL

Transmit end of the (valid, a) sample interface that feeds the sum-of-squares accumulator (part2).
- Buffers 8-bit samples in a small FIFO written by a host or bench.
- On a start command, streams exactly burst_len samples onto valid_out/a_out, one per cycle while data is available.
- Reports progress and completion, so accumulator runs become repeatable without hand-written stimulus.

---
 rtl/mac_sample_source.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mac_sample_source.sv
// Sample source for the sum-of-squares accumulator: FIFO-buffered samples streamed in bursts of burst_len.
// Optional build macro MAC_SOURCE_GAP_EN inserts one idle cycle after every sample sent.
`timescale 1ns/1ps
module mac_sample_source #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   input  logic              start,
   input  logic [CNT_W-1:0]  burst_len,
   output logic              valid_out,
   output logic [DATA_W-1:0] a_out,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sent_count,
   output logic              underrun,
   output logic              wr_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_DONE = 2'd2} state_t;

   state_t            state_r, state_nxt_s;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [AW:0]       occ_r;
   logic [CNT_W-1:0]  len_r, sent_r;
   logic              valid_r, busy_r, done_r, underrun_r, wr_drop_r;
   logic [DATA_W-1:0] a_r;
   logic              full_s, empty_s, push_s, pop_s, start_ok_s, gap_s;

   assign full_s     = (occ_r == OCC_FULL);
   assign empty_s    = (occ_r == {(AW+1){1'b0}});
   assign push_s     = wr_en && !full_s;
   assign pop_s      = (state_r == ST_SEND) && !empty_s && !gap_s;
   assign start_ok_s = (state_r == ST_IDLE) && start;

`ifdef MAC_SOURCE_GAP_EN
   logic gap_r;
   // Gap flag: one forced idle cycle after every pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) gap_r <= 1'b0;
      else       gap_r <= pop_s;
   end
   assign gap_s = gap_r;
`else
   assign gap_s = 1'b0;
`endif

   // Next-state decode; start is only honoured in IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (burst_len != {CNT_W{1'b0}}) state_nxt_s = ST_SEND;
               else                            state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (pop_s && ((sent_r + CNT_ONE) == len_r)) state_nxt_s = ST_DONE;
            else                                        state_nxt_s = ST_SEND;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_nxt_s;
   end

   // Storage array carries no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= wr_data;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         occ_r    <= {(AW+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         if (push_s && !pop_s)      occ_r <= occ_r + OCC_ONE;
         else if (pop_s && !push_s) occ_r <= occ_r - OCC_ONE;
         else                       occ_r <= occ_r;
      end
   end

   // Burst bookkeeping and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_r      <= {CNT_W{1'b0}};
         sent_r     <= {CNT_W{1'b0}};
         valid_r    <= 1'b0;
         a_r        <= {DATA_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         underrun_r <= 1'b0;
         wr_drop_r  <= 1'b0;
      end else begin
         if (start_ok_s) begin
            len_r  <= burst_len;
            sent_r <= {CNT_W{1'b0}};
         end else if (pop_s) begin
            sent_r <= sent_r + CNT_ONE;
         end
         valid_r <= pop_s;
         if (pop_s) a_r <= mem_r[rd_ptr_r];
         busy_r <= (state_nxt_s == ST_SEND);
         done_r <= (state_r == ST_DONE);
         if ((state_r == ST_SEND) && empty_s && !gap_s) underrun_r <= 1'b1;
         if (wr_en && full_s) wr_drop_r <= 1'b1;
      end
   end

   assign full       = full_s;
   assign empty      = empty_s;
   assign valid_out  = valid_r;
   assign a_out      = a_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign sent_count = sent_r;
   assign underrun   = underrun_r;
   assign wr_drop    = wr_drop_r;

endmodule
